// File: rtl/adc_responder.sv
// rtl/adc_responder.sv - SPI slave emulating a 2-channel 10-bit ADC for spi2adc loopback
module adc_responder #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_SDO    = 1'b1
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       adc_cs,
    input  logic       adc_sck,
    input  logic       sdata_to_adc,
    output logic       sdata_from_adc,
    input  logic [9:0] sample_ch0,
    input  logic [9:0] sample_ch1,
    output logic       cfg_valid,
    output logic       cfg_single,
    output logic       cfg_channel,
    output logic       frame_done,
    output logic       frame_abort
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_CFG,
        S_NULL,
        S_DATA,
        S_TRAIL
    } state_t;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_sck_prev;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [9:0] r_shift, w_shift_nxt;
    logic       r_sdo, w_sdo_nxt;
    logic       r_cfg_valid, w_cfg_valid_nxt;
    logic       r_single, w_single_nxt;
    logic       r_channel, w_channel_nxt;
    logic       r_frame_done, w_frame_done_nxt;
    logic       r_abort, w_abort_nxt;
    logic       r_done_seen, w_done_seen_nxt;

    logic        w_cs, w_sck, w_din, w_sck_rise, w_sck_fall;
    logic [10:0] w_diff_01, w_diff_10;
    logic [9:0]  w_sel;

    // cs synchroniser resets high so a reset never looks like a frame start
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_sync  <= '1;
            r_sck_sync <= '0;
            r_din_sync <= '0;
            r_sck_prev <= 1'b0;
        end else begin
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], adc_cs};
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], adc_sck};
            r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], sdata_to_adc};
            r_sck_prev <= w_sck;
        end
    end

    assign w_cs       = r_cs_sync[SYNC_STAGES-1];
    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_din      = r_din_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_prev;
    assign w_sck_fall = ~w_sck & r_sck_prev;

    // During CFG the shift register holds the captured bits: [1]=SGL, [0]=ODD
    assign w_diff_01 = {1'b0, sample_ch0} - {1'b0, sample_ch1};
    assign w_diff_10 = {1'b0, sample_ch1} - {1'b0, sample_ch0};

    always_comb begin
        w_sel = 10'd0;
        case ({r_shift[1], r_shift[0]})
            2'b10:   w_sel = sample_ch0;
            2'b11:   w_sel = sample_ch1;
            2'b00:   w_sel = w_diff_01[10] ? 10'd0 : w_diff_01[9:0];
            default: w_sel = w_diff_10[10] ? 10'd0 : w_diff_10[9:0];
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_shift      <= 10'd0;
            r_sdo        <= IDLE_SDO;
            r_cfg_valid  <= 1'b0;
            r_single     <= 1'b0;
            r_channel    <= 1'b0;
            r_frame_done <= 1'b0;
            r_abort      <= 1'b0;
            r_done_seen  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_sdo        <= w_sdo_nxt;
            r_cfg_valid  <= w_cfg_valid_nxt;
            r_single     <= w_single_nxt;
            r_channel    <= w_channel_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_abort      <= w_abort_nxt;
            r_done_seen  <= w_done_seen_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_shift_nxt      = r_shift;
        w_sdo_nxt        = r_sdo;
        w_cfg_valid_nxt  = 1'b0;
        w_single_nxt     = r_single;
        w_channel_nxt    = r_channel;
        w_frame_done_nxt = 1'b0;
        w_abort_nxt      = 1'b0;
        w_done_seen_nxt  = r_done_seen;

        // cs high overrides any SCK edge seen in the same cycle
        if (w_cs) begin
            w_state_nxt     = S_IDLE;
            w_sdo_nxt       = IDLE_SDO;
            w_cnt_nxt       = 4'd0;
            w_done_seen_nxt = 1'b0;
            w_abort_nxt     = (r_state == S_CFG) || (r_state == S_NULL) ||
                              (r_state == S_DATA) ||
                              ((r_state == S_TRAIL) && !r_done_seen);
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sdo_nxt   = IDLE_SDO;
                    w_state_nxt = S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (w_sck_rise && w_din) begin
                        w_state_nxt = S_CFG;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                S_CFG: begin
                    if (w_sck_rise) begin
                        w_shift_nxt = {r_shift[8:0], w_din};
                        w_cnt_nxt   = r_cnt + 4'd1;
                        if (r_cnt == 4'd2) begin
                            w_cfg_valid_nxt = 1'b1;
                            w_single_nxt    = r_shift[1];
                            w_channel_nxt   = r_shift[0];
                            w_shift_nxt     = w_sel;
                            w_state_nxt     = S_NULL;
                            w_cnt_nxt       = 4'd0;
                        end
                    end
                end
                S_NULL: begin
                    if (w_sck_fall) begin
                        w_sdo_nxt   = 1'b0;
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                S_DATA: begin
                    if (w_sck_fall) begin
                        w_sdo_nxt   = r_shift[9];
                        w_shift_nxt = {r_shift[8:0], 1'b0};
                        w_cnt_nxt   = r_cnt + 4'd1;
                        if (r_cnt == 4'd9) begin
                            w_state_nxt     = S_TRAIL;
                            w_cnt_nxt       = 4'd0;
                            w_done_seen_nxt = 1'b0;
                        end
                    end
                end
                S_TRAIL: begin
                    if (w_sck_rise && !r_done_seen) begin
                        w_frame_done_nxt = 1'b1;
                        w_done_seen_nxt  = 1'b1;
                    end
                    if (w_sck_fall) begin
                        w_sdo_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_sdo_nxt   = IDLE_SDO;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    assign sdata_from_adc = r_sdo;
    assign cfg_valid      = r_cfg_valid;
    assign cfg_single     = r_single;
    assign cfg_channel    = r_channel;
    assign frame_done     = r_frame_done;
    assign frame_abort    = r_abort;

endmodule

// File: tb/tb_adc_responder.sv
// tb/tb_adc_responder.sv - scoreboard bench for adc_responder acting as the SPI master
`timescale 1ns/1ps
module tb_adc_responder;

    localparam int SYNC = 2;
    localparam int HALF = 6;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       adc_cs;
    logic       adc_sck;
    logic       sdata_to_adc;
    logic       sdata_from_adc;
    logic [9:0] sample_ch0;
    logic [9:0] sample_ch1;
    logic       cfg_valid, cfg_single, cfg_channel, frame_done, frame_abort;

    int checks = 0;
    int errors = 0;

    logic [1:0]  q_cfg[$];
    logic [10:0] q_frame[$];
    bit          q_abort[$];
    logic [10:0] rx_word;

    adc_responder #(.SYNC_STAGES(SYNC), .IDLE_SDO(1'b1)) dut (
        .sysclk(sysclk),
        .rst_n(rst_n),
        .adc_cs(adc_cs),
        .adc_sck(adc_sck),
        .sdata_to_adc(sdata_to_adc),
        .sdata_from_adc(sdata_from_adc),
        .sample_ch0(sample_ch0),
        .sample_ch1(sample_ch1),
        .cfg_valid(cfg_valid),
        .cfg_single(cfg_single),
        .cfg_channel(cfg_channel),
        .frame_done(frame_done),
        .frame_abort(frame_abort)
    );

    always #10 sysclk = ~sysclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each DUT pulse pops one expectation
    always @(negedge sysclk) begin
        if (rst_n === 1'b1) begin
            if (cfg_valid) begin
                if (q_cfg.size() == 0) check("cfg_valid_unexpected", 1, 0);
                else check("cfg_sgl_odd", {30'd0, cfg_single, cfg_channel}, {30'd0, q_cfg.pop_front()});
            end
            if (frame_done) begin
                if (q_frame.size() == 0) check("frame_done_unexpected", 1, 0);
                else check("frame_data", {21'd0, rx_word}, {21'd0, q_frame.pop_front()});
            end
            if (frame_abort) begin
                if (q_abort.size() == 0) check("frame_abort_unexpected", 1, 0);
                else void'(q_abort.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge sysclk);
        #2;
    endtask

    task automatic expect_frame(input logic sgl, input logic odd, input logic [9:0] val);
        q_cfg.push_back({sgl, odd});
        q_frame.push_back({1'b0, val});
    endtask

    // stop_after >= 0: end the frame after that many data bits, by cs (use_reset=0) or rst_n
    task automatic run_frame(input int lead, input logic sgl, input logic odd,
                             input int stop_after, input bit use_reset,
                             input int chg_cycle, input logic [9:0] chg_val);
        int   n;
        int   rel;
        logic din;
        n = lead + 16;
        rx_word = '0;
        adc_cs = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < n; i++) begin
            rel = i - lead - 4;
            if (i < lead)           din = 1'b0;
            else if (i == lead)     din = 1'b1;
            else if (i == lead + 1) din = sgl;
            else if (i == lead + 2) din = odd;
            else if (i == lead + 3) din = 1'b1;
            else                    din = 1'b0;
            sdata_to_adc = din;
            if (rel == chg_cycle) sample_ch0 = chg_val;
            wait_clk(HALF);
            if (rel >= 0 && rel <= 10) rx_word = {rx_word[9:0], sdata_from_adc};
            adc_sck = 1'b1;
            wait_clk(HALF);
            adc_sck = 1'b0;
            if (stop_after >= 0 && rel == stop_after) begin
                wait_clk(HALF);
                check("sdo_before_stop", {31'd0, sdata_from_adc}, 32'd0);
                if (use_reset) begin
                    #5 rst_n = 1'b0;
                    #1;
                    check("rst_sdo", {31'd0, sdata_from_adc}, 32'd1);
                    check("rst_cfg_single", {31'd0, cfg_single}, 32'd0);
                    check("rst_cfg_channel", {31'd0, cfg_channel}, 32'd0);
                    adc_cs = 1'b1;
                    sdata_to_adc = 1'b0;
                    wait_clk(3);
                    rst_n = 1'b1;
                end else begin
                    adc_cs = 1'b1;
                    repeat (SYNC + 1) @(posedge sysclk);
                    #1;
                    check("abort_sdo_idle", {31'd0, sdata_from_adc}, 32'd1);
                end
                sdata_to_adc = 1'b0;
                wait_clk(HALF);
                return;
            end
        end
        wait_clk(HALF);
        adc_cs = 1'b1;
        sdata_to_adc = 1'b0;
        wait_clk(HALF);
    endtask

    initial begin
        rst_n = 1'b0;
        adc_cs = 1'b1;
        adc_sck = 1'b0;
        sdata_to_adc = 1'b0;
        sample_ch0 = 10'd0;
        sample_ch1 = 10'd0;
        #15;
        check("reset_sdo", {31'd0, sdata_from_adc}, 32'd1);
        check("reset_cfg_valid", {31'd0, cfg_valid}, 32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        check("reset_frame_abort", {31'd0, frame_abort}, 32'd0);
        check("reset_cfg_single", {31'd0, cfg_single}, 32'd0);
        check("reset_cfg_channel", {31'd0, cfg_channel}, 32'd0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(5);

        sample_ch0 = 10'h2A5;
        expect_frame(1'b1, 1'b0, 10'h2A5);
        run_frame(0, 1'b1, 1'b0, -1, 1'b0, -100, 10'd0);

        sample_ch1 = 10'h3FF;
        expect_frame(1'b1, 1'b1, 10'h3FF);
        run_frame(0, 1'b1, 1'b1, -1, 1'b0, -100, 10'd0);

        sample_ch0 = 10'd300;
        sample_ch1 = 10'd100;
        expect_frame(1'b0, 1'b0, 10'd200);
        run_frame(0, 1'b0, 1'b0, -1, 1'b0, -100, 10'd0);
        expect_frame(1'b0, 1'b1, 10'd0);
        run_frame(0, 1'b0, 1'b1, -1, 1'b0, -100, 10'd0);

        sample_ch0 = 10'h3C0;
        q_cfg.push_back(2'b10);
        q_abort.push_back(1'b1);
        run_frame(0, 1'b1, 1'b0, 4, 1'b0, -100, 10'd0);
        expect_frame(1'b1, 1'b0, 10'h3C0);
        run_frame(0, 1'b1, 1'b0, -1, 1'b0, -100, 10'd0);

        sample_ch0 = 10'h001;
        expect_frame(1'b1, 1'b0, 10'h001);
        run_frame(3, 1'b1, 1'b0, -1, 1'b0, 2, 10'h3FE);
        expect_frame(1'b1, 1'b0, 10'h3FE);
        run_frame(0, 1'b1, 1'b0, -1, 1'b0, -100, 10'd0);

        sample_ch1 = 10'h3C0;
        q_cfg.push_back(2'b11);
        run_frame(0, 1'b1, 1'b1, 4, 1'b1, -100, 10'd0);
        sample_ch0 = 10'd5;
        sample_ch1 = 10'd12;
        expect_frame(1'b0, 1'b1, 10'd7);
        run_frame(0, 1'b0, 1'b1, -1, 1'b0, -100, 10'd0);

        wait_clk(20);
        check("cfg_queue_drained", q_cfg.size(), 0);
        check("frame_queue_drained", q_frame.size(), 0);
        check("abort_queue_drained", q_abort.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
